truth_table_scanner: RTL

- Sequential stimulus and capture stage wrapped around a 3-input combinational logic gate module (e.g. the 0xD4 function).
- Upstream role: drives in1/in2/in3 through all 8 combinations. Downstream role: samples the gate's out after a settle window.
- Assembles the observed 8-bit truth table in Cello hex-name order and compares it against an expected table.
- Used for on-chip/bench self-check of the generated gate netlists.

---
 rtl/truth_table_scanner_pkg.sv | 22 ++
 rtl/truth_table_scanner_settle_counter.sv | 38 +++
 rtl/truth_table_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
// Contents: FSM state encoding, table/index/counter widths, and the helper
// that maps a stimulus row index onto its bit position in the hex-name table
// (row 000 lands in bit 7, row 111 in bit 0).
package cello_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int IDX_W = 3;
  localparam int ROWS  = 8;
  localparam int CNT_W = 8;

  function automatic logic [IDX_W-1:0] row_bit(input logic [IDX_W-1:0] idx);
    return IDX_W'(ROWS - 1) - idx;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle-window counter for the truth-table scanner.
// Counts the cycles a stimulus combination has been applied and flags the
// last cycle of the settle window.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset
//   i_clear - reload the count to zero (takes priority over i_en)
//   i_en    - advance the count by one
//   o_tc    - terminal count: count equals SETTLE-1
module settle_counter
  import cello_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      // The FSM leaves APPLY on terminal count, so with SETTLE <= 255 the
      // count never passes 255 and cannot wrap.
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives a 3-input gate through all 8 input rows,
// samples its output after a settle window and assembles the observed
// table in hex-name order, then compares it against EXPECTED.
//
// state  | meaning
// IDLE   | waiting for i_start; stimulus held at 000, last results visible
// APPLY  | current row driven, settle counter running
// SAMPLE | i_dut_out captured into the table for the current row
// DONE   | one-cycle completion pulse; match/mismatch valid
//
// Ports:
//   i_clk, i_rst      - clock (rising edge), synchronous active-high reset
//   i_start           - begin a scan, honoured only in IDLE
//   i_dut_out         - gate output, same clock domain
//   o_in1/o_in2/o_in3 - registered stimulus, {o_in1,o_in2,o_in3} = row index
//   o_busy            - high during APPLY/SAMPLE
//   o_done            - one-cycle pulse when the scan completes
//   o_table_out       - captured table, bit 7 = row 000, bit 0 = row 111
//   o_match           - o_table_out == EXPECTED
//   o_mismatch_mask   - o_table_out ^ EXPECTED
module truth_table_scanner
  import cello_scan_pkg::*;
#(
  parameter logic [ROWS-1:0] EXPECTED = 8'hD4,
  parameter int unsigned     SETTLE   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_dut_out,
  output logic            o_in1,
  output logic            o_in2,
  output logic            o_in3,
  output logic            o_busy,
  output logic            o_done,
  output logic [ROWS-1:0] o_table_out,
  output logic            o_match,
  output logic [ROWS-1:0] o_mismatch_mask
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_cnt_tc;
  logic             w_busy;
  logic             w_done;
  logic             w_last_row;
  logic [IDX_W-1:0] r_idx;
  logic [ROWS-1:0]  r_table;
  logic [ROWS-1:0]  w_table_next;
  logic             r_match;
  logic [ROWS-1:0]  r_mismatch;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_tc    (w_cnt_tc)
  );

  assign w_last_row = (r_idx == IDX_W'(ROWS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_cnt_clear  = 1'b1;
          w_next_state = APPLY;
        end
      end
      APPLY: begin
        w_busy   = 1'b1;
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          w_next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        w_busy      = 1'b1;
        w_cnt_clear = 1'b1;
        w_next_state = w_last_row ? DONE : APPLY;
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Table as it will be after this cycle's SAMPLE edge; used so the final
  // compare sees the last row and lands in the same cycle as o_done.
  always_comb begin
    w_table_next                = r_table;
    w_table_next[row_bit(r_idx)] = i_dut_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_table    <= '0;
      r_match    <= 1'b0;
      r_mismatch <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_idx      <= '0;
            r_table    <= '0;
            r_match    <= 1'b0;
            r_mismatch <= '0;
          end
        end
        SAMPLE: begin
          r_table <= w_table_next;
          if (w_last_row) begin
            r_match    <= (w_table_next == EXPECTED);
            r_mismatch <= w_table_next ^ EXPECTED;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_in1           = r_idx[2];
  assign o_in2           = r_idx[1];
  assign o_in3           = r_idx[0];
  assign o_busy          = w_busy;
  assign o_done          = w_done;
  assign o_table_out     = r_table;
  assign o_match         = r_match;
  assign o_mismatch_mask = r_mismatch;

endmodule
